// File: rtl/reg_bank_scan_8.sv
// Eight-entry register bank feeding an 8:1 mux, plus a dwell-timed scan sequencer
// that walks the mux select across all channels once or continuously.
module reg_bank_scan_8 #(
   parameter int N     = 8,
   parameter int DWELL = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [2:0]   waddr,
   input  logic [N-1:0] wdata,
   input  logic         clr,
   input  logic         start,
   input  logic         stop,
   input  logic         cont,
   output logic [N-1:0] q0,
   output logic [N-1:0] q1,
   output logic [N-1:0] q2,
   output logic [N-1:0] q3,
   output logic [N-1:0] q4,
   output logic [N-1:0] q5,
   output logic [N-1:0] q6,
   output logic [N-1:0] q7,
   output logic [2:0]   sel,
   output logic         busy,
   output logic         chan_valid,
   output logic         done
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [7:0] LAST = 8'(DWELL - 1);

   logic [7:0][N-1:0] regs;
   state_t            state;
   logic [7:0]        cnt;

   // clr beats we so a clear is never partially undone by a same-cycle write
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      regs        <= '0;
      else if (clr) regs        <= '0;
      else if (we)  regs[waddr] <= wdata;
   end

   assign q0 = regs[0];
   assign q1 = regs[1];
   assign q2 = regs[2];
   assign q3 = regs[3];
   assign q4 = regs[4];
   assign q5 = regs[5];
   assign q6 = regs[6];
   assign q7 = regs[7];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sel        <= '0;
         busy       <= 1'b0;
         chan_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         chan_valid <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  state      <= SCAN;
                  sel        <= '0;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  chan_valid <= 1'b1;
               end
            end
            SCAN: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (cnt < LAST) begin
                  cnt <= cnt + 8'd1;
               end else begin
                  cnt <= '0;
                  if (sel != 3'd7) begin
                     sel        <= sel + 3'd1;
                     chan_valid <= 1'b1;
                  end else if (cont) begin
                     sel        <= '0;
                     chan_valid <= 1'b1;
                  end else begin
                     // single pass complete: sel parks on channel 7
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bank_scan_8.sv
// Bench for reg_bank_scan_8: three instances (DWELL 4, 2, 1) on shared stimulus,
// checked every cycle against a position-based model plus literal spot checks.
module tb_reg_bank_scan_8;

   localparam int DWV[3] = '{4, 2, 1};

   logic       clk = 1'b0;
   logic       rst, we, clr, start, stop, cont;
   logic [2:0] waddr;
   logic [7:0] wdata;

   logic [7:0] d_q[3][8];
   logic [2:0] d_sel[3];
   logic       d_busy[3], d_cv[3], d_done[3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      reg_bank_scan_8 #(.N(8), .DWELL(DWV[k])) dut (
         .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
         .clr(clr), .start(start), .stop(stop), .cont(cont),
         .q0(d_q[k][0]), .q1(d_q[k][1]), .q2(d_q[k][2]), .q3(d_q[k][3]),
         .q4(d_q[k][4]), .q5(d_q[k][5]), .q6(d_q[k][6]), .q7(d_q[k][7]),
         .sel(d_sel[k]), .busy(d_busy[k]), .chan_valid(d_cv[k]), .done(d_done[k])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a scan is a position counter p since start; sel=p/DWELL, a new
   // channel begins whenever p is a multiple of DWELL, a pass is 8*DWELL cycles.
   logic [7:0] m_reg[8];
   logic       m_act[3], m_cv[3], m_done[3];
   logic [2:0] m_sel[3];
   int         m_pos[3];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) m_reg[i] <= '0;
         for (int k = 0; k < 3; k++) begin
            m_act[k] <= 0; m_cv[k] <= 0; m_done[k] <= 0; m_sel[k] <= '0; m_pos[k] <= 0;
         end
      end else begin
         if (clr) for (int i = 0; i < 8; i++) m_reg[i] <= '0;
         else if (we) m_reg[waddr] <= wdata;
         for (int k = 0; k < 3; k++) begin
            m_cv[k]   <= 0;
            m_done[k] <= 0;
            if (!m_act[k]) begin
               if (start && !stop) begin
                  m_act[k] <= 1; m_pos[k] <= 0; m_sel[k] <= '0; m_cv[k] <= 1;
               end
            end else if (stop) begin
               m_act[k] <= 0;
            end else if (m_pos[k] + 1 == 8 * DWV[k]) begin
               if (cont) begin
                  m_pos[k] <= 0; m_sel[k] <= '0; m_cv[k] <= 1;
               end else begin
                  m_act[k] <= 0; m_done[k] <= 1;
               end
            end else begin
               m_pos[k] <= m_pos[k] + 1;
               m_sel[k] <= 3'((m_pos[k] + 1) / DWV[k]);
               m_cv[k]  <= ((m_pos[k] + 1) % DWV[k]) == 0;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("sel[%0d]", k),  32'(d_sel[k]),  32'(m_sel[k]));
         chk($sformatf("busy[%0d]", k), 32'(d_busy[k]), 32'(m_act[k]));
         chk($sformatf("cv[%0d]", k),   32'(d_cv[k]),   32'(m_cv[k]));
         chk($sformatf("done[%0d]", k), 32'(d_done[k]), 32'(m_done[k]));
         chk($sformatf("cv_and_done[%0d]", k), 32'(d_cv[k] & d_done[k]), 32'd0);
         for (int i = 0; i < 8; i++)
            chk($sformatf("q[%0d][%0d]", k, i), 32'(d_q[k][i]), 32'(m_reg[i]));
      end
   end

   int n_busy, n_cv, n_done, done_at, n_busy1, n_cv1, held;

   initial begin
      rst = 1; we = 0; clr = 0; start = 0; stop = 0; cont = 0; waddr = '0; wdata = '0;
      repeat (2) @(negedge clk);
      rst = 0;
      chk("rst_sel", 32'(d_sel[0]), 32'd0);
      chk("rst_busy", 32'(d_busy[0]), 32'd0);

      // bank writes then clear overriding a write
      we = 1; waddr = 3'd3; wdata = 8'hA5;
      @(negedge clk); waddr = 3'd7; wdata = 8'h3C;
      @(negedge clk); we = 0;
      chk("q3_wr", 32'(d_q[0][3]), 32'hA5);
      chk("q7_wr", 32'(d_q[0][7]), 32'h3C);
      clr = 1; we = 1; waddr = 3'd0; wdata = 8'hFF;
      @(negedge clk); clr = 0; we = 0;
      for (int i = 0; i < 8; i++) chk($sformatf("q%0d_clr", i), 32'(d_q[0][i]), 32'd0);

      // start+stop together in IDLE is a no-op
      start = 1; stop = 1;
      @(negedge clk); start = 0; stop = 0;
      chk("startstop_idle", 32'(d_busy[0]), 32'd0);

      // single pass, with a write to the live channel mid-scan
      cont = 0; start = 1;
      @(negedge clk); start = 0;
      n_busy = 0; n_cv = 0; n_done = 0; done_at = -1; n_busy1 = 0; n_cv1 = 0;
      for (int j = 0; j < 40; j++) begin
         n_busy += int'(d_busy[0]); n_cv += int'(d_cv[0]); n_done += int'(d_done[0]);
         n_busy1 += int'(d_busy[2]); n_cv1 += int'(d_cv[2]);
         if (d_done[0] && done_at < 0) done_at = j;
         if (j == 6) begin
            chk("q1_live_wr", 32'(d_q[0][1]), 32'h55);
            chk("sel_after_wr", 32'(d_sel[0]), 32'd1);
         end
         if (j == 5) begin we = 1; waddr = d_sel[0]; wdata = 8'h55; end
         else we = 0;
         @(negedge clk);
      end
      chk("sp_busy_cycles", 32'(n_busy), 32'd32);
      chk("sp_cv_pulses", 32'(n_cv), 32'd8);
      chk("sp_done_pulses", 32'(n_done), 32'd1);
      chk("sp_done_cycle", 32'(done_at), 32'd32);
      chk("sp_sel_final", 32'(d_sel[0]), 32'd7);
      chk("d1_busy_cycles", 32'(n_busy1), 32'd8);
      chk("d1_cv_cycles", 32'(n_cv1), 32'd8);

      // continuous scan on the DWELL=2 instance, start re-pulsed mid-scan
      cont = 1; start = 1;
      @(negedge clk); start = 0;
      n_done = 0;
      for (int j = 0; j < 20; j++) begin
         chk($sformatf("cont_sel_%0d", j), 32'(d_sel[1]), 32'((j / 2) % 8));
         n_done += int'(d_done[1]);
         start = (j == 7);
         @(negedge clk);
      end
      start = 0;
      chk("cont_no_done", 32'(n_done), 32'd0);
      held = int'(d_sel[1]);
      stop = 1;
      @(negedge clk); stop = 0;
      chk("stop_busy", 32'(d_busy[1]), 32'd0);
      chk("stop_sel_held", 32'(d_sel[1]), 32'(held));

      // async reset in the middle of a scan
      we = 1; waddr = 3'd3; wdata = 8'hA5; start = 1;
      @(negedge clk); we = 0; start = 0;
      repeat (5) @(negedge clk);
      #2 rst = 1;
      #1;
      chk("arst_sel", 32'(d_sel[0]), 32'd0);
      chk("arst_busy", 32'(d_busy[0]), 32'd0);
      chk("arst_done", 32'(d_done[0]), 32'd0);
      chk("arst_q1", 32'(d_q[0][1]), 32'd0);
      chk("arst_q3", 32'(d_q[0][3]), 32'd0);
      @(negedge clk); rst = 0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_bank_scan_8.md
Name: reg_bank_scan_8

Overview:
- Upstream companion to the team's 8-input, N-bit select mux.
- Holds eight N-bit data registers written through a single write port. Each register drives one mux data input (q0 to in0 … q7 to in7).
- A dwell-timed scan sequencer drives the mux 3-bit select, so every register is presented downstream in turn.
- Supports single-pass and continuous scanning, with busy/done/channel-valid status for the consuming logic.

Parameters:
- N, 8, data width of each register (matches the mux width).
- DWELL, 4, clock cycles each channel stays selected; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- we  input  1  write enable for the register bank
- waddr  input  3  register index written when we=1
- wdata  input  N  write data
- clr  input  1  synchronous clear of all eight registers
- start  input  1  begin scan (sampled only in IDLE)
- stop  input  1  abort scan
- cont  input  1  1=continuous wrap, 0=single pass; sampled every dwell end
- q0..q7  output  N each  register contents, to mux in0..in7
- sel  output  3  channel select, to mux Sel
- busy  output  1  high while in SCAN
- chan_valid  output  1  one-cycle pulse on the first cycle a new sel value is presented
- done  output  1  one-cycle pulse when a single pass completes

Behaviour:
- Reset (async, rst=1): q0..q7=0, sel=0, busy=0, chan_valid=0, done=0, FSM=IDLE, dwell counter=0. Reset mid-scan aborts immediately with no done pulse.
- All outputs are registered. Writes and status changes appear one cycle after the sampling edge.
- Register bank:
  - clr=1 zeroes all eight registers at the next edge and overrides we in that cycle.
  - Otherwise we=1 loads wdata into register waddr.
  - Writes are independent of scan state. A write to the currently selected register is visible on its q output the next cycle; sel is unaffected.
- FSM states: IDLE, SCAN. Dwell counter width = 8 bits.
- IDLE:
  - If start=1 and stop=0, go to SCAN at the edge: sel=0, counter=0, busy=1, chan_valid=1.
  - Otherwise stay in IDLE. sel holds its last value and busy=0.
  - start and stop together in IDLE: stop wins, remain IDLE.
- SCAN, per cycle:
  - If stop=1: go to IDLE next edge. busy=0, done=0, chan_valid=0, sel holds.
  - Else if counter<DWELL-1: counter+1, chan_valid=0.
  - Else (dwell end): counter=0.
    - If sel<7: sel+1, chan_valid=1.
    - If sel==7 and cont=1: sel wraps to 0, chan_valid=1.
    - If sel==7 and cont=0: go to IDLE, done=1 for one cycle, busy=0, sel holds 7.
  - start is ignored while in SCAN.
- DWELL=1: sel advances every cycle and chan_valid stays high continuously while scanning.
- Single-pass timing: busy is high for exactly 8*DWELL cycles. done is asserted in the first cycle busy is low.
- done and chan_valid are never high in the same cycle.

Test Plan:
- Reset: assert rst mid-cycle during a scan → all q=0, sel=0, busy=0, done=0 immediately, before the next clock edge.
- Write/read: write 0xA5 to addr 3 and 0x3C to addr 7, then clr on a cycle with we=1, addr 0, data 0xFF → q3=0xA5 and q7=0x3C after the writes; all q=0 after clr, and q0 stays 0 because clr overrides we.
- Single pass, DWELL=4, cont=0: pulse start → sel steps 0..7 every 4 cycles; chan_valid pulses 8 times; busy high for 32 cycles; done pulses once on cycle 33; sel ends at 7.
- Continuous, DWELL=2, cont=1: run 20 cycles → sel sequence 0,0,1,1,…,7,7,0,0,1,1; no done pulse; raising stop → busy=0 next cycle with sel held.
- Edge cases:
  - start+stop same cycle in IDLE → stays IDLE.
  - start during SCAN → ignored, with no restart of sel.
  - DWELL=1 → sel increments every cycle and chan_valid is constantly high for 8 cycles.
- Write during scan: write 0x55 to the register currently selected by sel → its q updates next cycle; the sel and counter sequence is undisturbed.
